mvm_shift_add: RTL and testbench

- Downstream stage of the crossbar MVM unit.
- Consumes one crossbar output vector per input bit-slice and shift-accumulates each column into a full-precision dot-product result.
- Two's-complement inputs are supported: the MSB slice is subtracted.
- Presents the finished result vector to the next stage (ALU / output register file) with a valid/ready handshake.

---
 rtl/mvm_shift_add.sv | 64 ++++++
 tb/tb_mvm_shift_add.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/mvm_shift_add.sv
// mvm_shift_add: shift-accumulates per-column crossbar slice results into full-precision dot products.
module mvm_shift_add #(
   parameter int XBAR_SIZE  = 16,
   parameter int OUT_BITS   = 16,
   parameter int NUM_SLICES = 16,
   parameter int SLICE_BITS = 1,
   parameter int ACC_BITS   = 32
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 start,
   input  logic                                 signed_mode,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   input  logic [XBAR_SIZE-1:0][OUT_BITS-1:0]   xbar_output,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic [XBAR_SIZE-1:0][ACC_BITS-1:0]   acc_out,
   output logic                                 busy
);
   localparam int CW = NUM_SLICES > 1 ? $clog2(NUM_SLICES) : 1;
   typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
   state_t state;
   logic [CW-1:0] slice_cnt;
   logic sgn, last, take;
   logic [XBAR_SIZE-1:0][ACC_BITS-1:0] acc, term, nxt;
   assign in_ready  = state == ACCUM;
   assign out_valid = state == HOLD;
   assign busy      = state != IDLE;
   assign acc_out   = acc;
   assign take      = in_valid & in_ready;
   assign last      = slice_cnt == CW'(NUM_SLICES - 1);
   // the MSB slice carries negative weight for two's-complement inputs
   always_comb begin
      for (int i = 0; i < XBAR_SIZE; i++) begin
         term[i] = ACC_BITS'(xbar_output[i]) << (int'(slice_cnt) * SLICE_BITS);
         nxt[i]  = (sgn && last) ? acc[i] - term[i] : acc[i] + term[i];
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         slice_cnt <= '0;
         sgn       <= 1'b0;
         acc       <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               acc       <= '0;
               slice_cnt <= '0;
               sgn       <= signed_mode;
               state     <= ACCUM;
            end
            ACCUM: if (take) begin
               acc       <= nxt;
               slice_cnt <= last ? '0 : slice_cnt + 1'b1;
               state     <= last ? HOLD : ACCUM;
            end
            HOLD: if (out_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mvm_shift_add.sv
// tb_mvm_shift_add: directed self-checking bench for mvm_shift_add.
module tb_mvm_shift_add;
   logic clk = 1'b0, reset = 1'b1, start = 1'b0, signed_mode = 1'b0;
   logic in_valid = 1'b0, out_ready = 1'b0;
   logic in_ready, out_valid, busy;
   logic [3:0][7:0] xbar = '0;
   logic [3:0][15:0] acc_out;
   int checks = 0, errors = 0;

   mvm_shift_add #(.XBAR_SIZE(4), .OUT_BITS(8), .NUM_SLICES(4), .SLICE_BITS(1), .ACC_BITS(16)) dut (
      .clk(clk), .reset(reset), .start(start), .signed_mode(signed_mode),
      .in_valid(in_valid), .in_ready(in_ready), .xbar_output(xbar),
      .out_valid(out_valid), .out_ready(out_ready), .acc_out(acc_out), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string tag, input logic [15:0] e);
      for (int i = 0; i < 4; i++) chk(tag, 32'(acc_out[i]), 32'(e));
   endtask

   task automatic do_start(input logic sm);
      start = 1'b1;
      signed_mode = sm;
      tick();
      start = 1'b0;
      signed_mode = 1'b0;
   endtask

   task automatic beat(input logic [3:0][7:0] d);
      in_valid = 1'b1;
      xbar = d;
      tick();
      in_valid = 1'b0;
      xbar = '0;
   endtask

   task automatic drain();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      tick(2);
      reset = 1'b0;
      tick();
      chk("rst_in_ready", 32'(in_ready), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk_all("rst_acc", 16'd0);
      // idle ignores beats
      beat({4{8'd9}});
      chk("idle_busy", 32'(busy), 0);

      // 1: unsigned
      do_start(1'b0);
      chk("s1_in_ready", 32'(in_ready), 1);
      chk("s1_busy", 32'(busy), 1);
      for (int k = 0; k < 3; k++) beat({4{8'd3}});
      chk("s1_not_yet", 32'(out_valid), 0);
      chk("s1_busy_mid", 32'(busy), 1);
      beat({4{8'd3}});
      chk("s1_out_valid", 32'(out_valid), 1);
      chk("s1_busy_hold", 32'(busy), 1);
      chk("s1_in_ready_hold", 32'(in_ready), 0);
      chk_all("s1_acc", 16'd45);
      drain();
      chk("s1_idle_valid", 32'(out_valid), 0);
      chk("s1_idle_busy", 32'(busy), 0);
      chk_all("s1_acc_kept", 16'd45);

      // 2: signed
      do_start(1'b1);
      for (int k = 0; k < 4; k++) beat({4{8'd3}});
      chk("s2_out_valid", 32'(out_valid), 1);
      chk_all("s2_acc", 16'hFFFD);
      drain();

      // 3: bubbles
      do_start(1'b0);
      beat({8'd4, 8'd3, 8'd2, 8'd1});
      beat({8'd4, 8'd3, 8'd2, 8'd1});
      tick(2);
      chk("s3_bubble_ready", 32'(in_ready), 1);
      beat({8'd4, 8'd3, 8'd2, 8'd1});
      tick(5);
      chk("s3_bubble_valid", 32'(out_valid), 0);
      beat({8'd4, 8'd3, 8'd2, 8'd1});
      chk("s3_out_valid", 32'(out_valid), 1);
      chk("s3_acc0", 32'(acc_out[0]), 15);
      chk("s3_acc1", 32'(acc_out[1]), 30);
      chk("s3_acc2", 32'(acc_out[2]), 45);
      chk("s3_acc3", 32'(acc_out[3]), 60);

      // 4: backpressure with garbage start/in_valid
      in_valid = 1'b1;
      start = 1'b1;
      xbar = {4{8'hAA}};
      for (int k = 0; k < 6; k++) begin
         tick();
         chk("s4_valid", 32'(out_valid), 1);
         chk("s4_in_ready", 32'(in_ready), 0);
         chk("s4_acc0", 32'(acc_out[0]), 15);
         chk("s4_acc3", 32'(acc_out[3]), 60);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      start = 1'b0;
      in_valid = 1'b0;
      xbar = '0;
      chk("s4_idle_valid", 32'(out_valid), 0);
      chk("s4_idle_busy", 32'(busy), 0);
      tick();
      chk("s4_start_dropped", 32'(busy), 0);

      // 5: reset mid-ACCUM
      do_start(1'b1);
      beat({4{8'd3}});
      beat({4{8'd3}});
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("s5_in_ready", 32'(in_ready), 0);
      chk("s5_out_valid", 32'(out_valid), 0);
      chk("s5_busy", 32'(busy), 0);
      chk_all("s5_acc", 16'd0);
      do_start(1'b0);
      for (int k = 0; k < 4; k++) beat({4{8'd3}});
      chk("s5_out_valid2", 32'(out_valid), 1);
      chk_all("s5_acc2", 16'd45);
      drain();

      // 6: max values, start ignored during ACCUM
      do_start(1'b0);
      beat({4{8'd255}});
      start = 1'b1;
      tick();
      chk("s6_ready_after_start", 32'(in_ready), 1);
      beat({4{8'd255}});
      start = 1'b0;
      beat({4{8'd255}});
      beat({4{8'd255}});
      chk("s6_out_valid", 32'(out_valid), 1);
      chk_all("s6_acc", 16'd3825);
      drain();
      chk("s6_idle", 32'(busy), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
